unsigned_div_16x8: RTL and testbench
====================================

Name: unsigned_div_16x8

Overview:
Sequential unsigned restoring divider. It is the inverse of the 8x8 LUT multiplier: it recovers X from a product C and a known constant A (X = C / A) and also reports the remainder. It uses a valid/ready handshake on both sides and computes one quotient bit per clock, so the datapath is a single shared subtractor. It sits downstream of the multiplier and serves as the reference checker and decoder for multiplier outputs.

Parameters:
DW, 16, dividend (C) and quotient width
VW, 8, divisor (A) and remainder width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dividend/divisor presented
in_ready  out  1  block can accept a new operation
C  in  DW  unsigned dividend
A  in  VW  unsigned divisor
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
X  out  DW  quotient
R  out  VW  remainder
div_by_zero  out  1  set with the result when A was 0

Behaviour:
- Reset is asynchronous and active-low. Clock is clk and reset is rst_n. The polarity and synchronicity are fixed.
- Reset values: in_ready=1, out_valid=0, X=0, R=0, div_by_zero=0, state=IDLE, iteration counter=0.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch C and A.
  - If A!=0: clear the partial remainder (VW+1 bits), set counter=0, go to CALC.
  - If A==0: go directly to DONE with X=all ones, R=C[VW-1:0], div_by_zero=1.
- CALC:
  - in_ready=0.
  - Each cycle: shift the dividend MSB into the partial remainder, i.e. trial = {rem[VW-1:0], dividend_msb}.
  - If trial>=A: rem = trial-A and the quotient bit is 1. Otherwise rem = trial and the quotient bit is 0.
  - The quotient bit shifts into the X LSB.
  - The counter increments. After the DW-th iteration (counter==DW-1), go to DONE.
- DONE:
  - out_valid=1. X, R and div_by_zero are stable.
  - On out_ready go to IDLE. out_valid drops on that edge.
- Latency, measured from the accept edge:
  - A!=0: out_valid is high after exactly DW edges (16 cycles).
  - A==0: out_valid is high after 1 edge.
- Throughput: in_ready is high only in IDLE, so the minimum period between accepts is DW+2 cycles with out_ready tied high.
- in_valid outside IDLE is ignored. C and A may change freely after acceptance and do not affect the computation in progress.
- Backpressure: DONE holds indefinitely while out_ready=0. Outputs must not change while held.
- out_ready is ignored outside DONE.
- X, R and div_by_zero keep their last result in IDLE and CALC. X/R internal shift registers must not corrupt the visible outputs, so use separate working registers.
- div_by_zero clears on the next accept.
- Invariant for A!=0: X*A+R == C and R<A. Full DW-bit quotient is supported (e.g. A=1 gives X=C).
- Reset asserted mid-CALC or mid-DONE aborts immediately to reset values. There is no partial output.

Test Plan:
- Accept C=510, A=2 (a multiplier product, 2*255) -> 16 cycles later out_valid=1, X=255, R=0, div_by_zero=0.
- C=65535, A=1 -> X=65535, R=0. Then C=1000, A=7 -> X=142, R=6. Then C=5, A=200 -> X=0, R=5.
- C=300, A=0 -> out_valid after 1 cycle, X=65535, R=44, div_by_zero=1. Next op C=10, A=3 -> X=3, R=1, div_by_zero=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid, X and R constant and in_ready=0. Raise out_ready -> out_valid falls next edge and in_ready rises.
- Hold in_valid=1 with changing C/A during CALC -> no new accept and the result matches the first operands. Sweep C=A*X for A=2 and X=0..255 -> every result is X, R=0.
- Pulse rst_n low at cycle 8 of CALC -> all outputs return to reset values immediately (async). After release, a new op C=100, A=10 gives X=10, R=0.

Source files
------------

// File: rtl/unsigned_div_16x8.sv
// unsigned_div_16x8
// -----------------------------------------------------------------------------
// Sequential unsigned restoring divider: X = C / A, R = C % A. It recovers the
// multiplicand from an 8x8 multiplier product and a known constant. It produces
// one quotient bit per clock through a single shared subtractor.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor presented
//   in_ready     high only in IDLE; block can accept an operation
//   C  [DW-1:0]  unsigned dividend
//   A  [VW-1:0]  unsigned divisor
//   out_valid    result held valid (DONE state)
//   out_ready    consumer accepts result
//   X  [DW-1:0]  quotient (all ones on divide by zero)
//   R  [VW-1:0]  remainder (C[VW-1:0] on divide by zero)
//   div_by_zero  set with the result when A was 0
// -----------------------------------------------------------------------------
module unsigned_div_16x8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] C,
    input  logic [VW-1:0] A,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] X,
    output logic [VW-1:0] R,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] counter;
    logic [VW-1:0] divisor_reg;
    logic [DW-1:0] dividend_work;
    logic [DW-1:0] quot_work;
    logic [VW:0]   rem_work;

    logic [VW:0]   trial;
    logic          trial_ge;
    logic [VW:0]   rem_next;
    logic [DW-1:0] quot_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: bring down the next dividend bit, subtract the divisor
    // if it fits. The partial remainder always stays below A, so its top bit is
    // zero between steps. ORing it in only keeps the compare well defined.
    always_comb begin
        trial     = {rem_work[VW-1:0], dividend_work[DW-1]};
        trial_ge  = rem_work[VW] | (trial >= {1'b0, divisor_reg});
        rem_next  = trial_ge ? (trial - {1'b0, divisor_reg}) : trial;
        quot_next = {quot_work[DW-2:0], trial_ge};
    end

    // Control plus datapath. Working registers are separate from X/R, so the
    // visible result only changes on the final iteration or on a divide by zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            divisor_reg   <= '0;
            dividend_work <= '0;
            quot_work     <= '0;
            rem_work      <= '0;
            X             <= '0;
            R             <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_reg   <= A;
                        dividend_work <= C;
                        if (A != '0) begin
                            rem_work    <= '0;
                            quot_work   <= '0;
                            counter     <= '0;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end else begin
                            X           <= '1;
                            R           <= C[VW-1:0];
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    dividend_work <= dividend_work << 1;
                    rem_work      <= rem_next;
                    quot_work     <= quot_next;
                    counter       <= counter + 1'b1;
                    if (counter == CW'(DW - 1)) begin
                        X     <= quot_next;
                        R     <= rem_next[VW-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_div_16x8.sv
// tb_unsigned_div_16x8
// Self-checking bench for unsigned_div_16x8. Expected results are queued when an
// operation is sent and popped when the divider presents its result.
module tb_unsigned_div_16x8;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] C = '0;
    logic [VW-1:0] A = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] X;
    logic [VW-1:0] R;
    logic          div_by_zero;

    typedef struct {
        logic [DW-1:0] x;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    unsigned_div_16x8 #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .C          (C),
        .A          (A),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .X          (X),
        .R          (R),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Present one operation at a negedge and queue its expected result.
    // Returns at the negedge right after the accepting posedge.
    task automatic send_op(input logic [DW-1:0] c, input logic [VW-1:0] a,
                           input logic [DW-1:0] ex, input logic [VW-1:0] er,
                           input logic edbz);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        C        = c;
        A        = a;
        in_valid = 1'b1;
        exp_q.push_back('{x: ex, r: er, dbz: edbz});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard, then
    // handshake the result away. exp_lat < 0 skips the latency check.
    task automatic collect(input int exp_lat, input string name);
        exp_t e;
        int   lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_compared++;
        if (out_valid !== 1'b1 || (exp_lat >= 0 && lat != exp_lat)) begin
            n_mismatched++;
            $display("[TB] FAIL %s_latency: out_valid=%b after %0d cycles, required 1 after %0d",
                     name, out_valid, lat, exp_lat);
        end
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_queue: result seen with %0d expected entries, required 1", name, 0);
        end else begin
            e = exp_q.pop_front();
            if (X !== e.x || R !== e.r || div_by_zero !== e.dbz) begin
                n_mismatched++;
                $display("[TB] FAIL %s_result: X=%0d R=%0d dbz=%b, required X=%0d R=%0d dbz=%b",
                         name, X, R, div_by_zero, e.x, e.r, e.dbz);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b, required 0 and 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || X !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_values: in_ready=%b out_valid=%b X=%0d R=%0d dbz=%b, required 1 0 0 0 0",
                     in_ready, out_valid, X, R, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_op(16'd510, 8'd2, 16'd255, 8'd0, 1'b0);
        collect(16, "basic_510_2");
        send_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
        collect(16, "full_65535_1");
        send_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        collect(16, "mid_1000_7");
        send_op(16'd5, 8'd200, 16'd0, 8'd5, 1'b0);
        collect(16, "small_5_200");
    endtask

    task automatic test_div_zero();
        send_op(16'd300, 8'd0, 16'hFFFF, 8'd44, 1'b1);
        collect(0, "divzero_300");
        send_op(16'd10, 8'd3, 16'd3, 8'd1, 1'b0);
        collect(16, "after_divzero");
    endtask

    task automatic test_backpressure();
        int waited = 0;
        send_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        while (out_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_compared++;
            if (out_valid !== 1'b1 || X !== 16'd142 || R !== 8'd6 || in_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL backpressure_hold%0d: out_valid=%b X=%0d R=%0d in_ready=%b, required 1 142 6 0",
                         i, out_valid, X, R, in_ready);
            end
        end
        collect(-1, "backpressure");
    endtask

    task automatic test_busy_ignore();
        send_op(16'd5000, 8'd13, 16'd384, 8'd8, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            C = 16'($urandom);
            A = 8'($urandom);
            @(negedge clk);
            n_compared++;
            if (in_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL busy_ready%0d: in_ready=%b required 0", i, in_ready);
            end
        end
        in_valid = 1'b0;
        collect(-1, "busy_ignore");
    endtask

    task automatic test_sweep();
        for (int x = 0; x < 256; x++) begin
            send_op(16'(2 * x), 8'd2, 16'(x), 8'd0, 1'b0);
            collect(16, "sweep_a2");
        end
    endtask

    task automatic test_async_reset();
        send_op(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || X !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: in_ready=%b out_valid=%b X=%0d R=%0d dbz=%b, required 1 0 0 0 0",
                     in_ready, out_valid, X, R, div_by_zero);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0);
        collect(16, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_busy_ignore();
        test_sweep();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
